// File: rtl/ad_pkg.sv
// Shared types, sizes and the BCD digit-adjust helper for the ADC averaging/display path.
// No logic of its own, so there is no latency or backpressure here.
package ad_pkg;

    typedef enum logic [2:0] {
        S_CLR,
        S_IDLE,
        S_ACCUM,
        S_SCALE,
        S_CONV,
        S_DONE
    } state_t;

    localparam int MV_W        = 14;
    localparam int BCD_DIGITS  = 4;
    localparam int CONV_CYCLES = 14;
    localparam int LATENCY     = 17;

    // Double-dabble pre-shift step: every digit of 5 or more gets 3 added.
    function automatic logic [4*BCD_DIGITS-1:0] bcd_adjust(input logic [4*BCD_DIGITS-1:0] d);
        logic [4*BCD_DIGITS-1:0] r;
        r = d;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to packed-BCD converter, one bit per cycle.
// 14 cycles after load; a load while converting restarts it, and there is no stall input.
module bin2bcd_seq
    import ad_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [MV_W-1:0]         bin,
    output logic [4*BCD_DIGITS-1:0] bcd,
    output logic                    done
);

    localparam int CNT_W = $clog2(CONV_CYCLES);

    logic [4*BCD_DIGITS-1:0] digits;
    logic [4*BCD_DIGITS-1:0] adj;
    logic [MV_W-1:0]         shreg;
    logic [CNT_W-1:0]        cnt;
    logic                    active;
    logic                    last_iter;

    assign adj       = bcd_adjust(digits);
    assign last_iter = active && (cnt == CNT_W'(CONV_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digits <= '0;
            shreg  <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (load) begin
            digits <= '0;
            shreg  <= bin;
            cnt    <= '0;
            active <= 1'b1;
        end else if (active) begin
            {digits, shreg} <= {adj[4*BCD_DIGITS-2:0], shreg, 1'b0};
            cnt             <= cnt + CNT_W'(1);
            if (last_iter) begin
                active <= 1'b0;
            end
        end
    end

    // done marks the cycle whose closing edge finishes the conversion; bcd is final right after it.
    assign done = last_iter;
    assign bcd  = digits;

endmodule

// File: rtl/ad_avg_bcd.sv
// Moving average of ADC samples, scaled to mV and converted to 4 BCD digits for the display.
// Result_Valid 17 cycles after the Data_Valid edge; edges arriving while Busy are dropped and flag Overrun.
module ad_avg_bcd
    import ad_pkg::*;
#(
    parameter int AVG_LOG2 = 3,
    parameter int VREF_MV  = 5000,
    parameter int DATA_W   = 10
) (
    input  logic                    CLK,
    input  logic                    RSTn,
    input  logic [DATA_W-1:0]       Data_In,
    input  logic                    Data_Valid,
    output logic [DATA_W-1:0]       Avg_Data,
    output logic [4*BCD_DIGITS-1:0] BCD_Out,
    output logic                    Result_Valid,
    output logic                    Busy,
    output logic                    Overrun
);

    localparam int WIN    = 1 << AVG_LOG2;
    localparam int PTR_W  = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
    localparam int SUM_W  = DATA_W + AVG_LOG2;
    localparam int PROD_W = 24;

    state_t                  state, next_state;
    logic                    dv_q;
    logic                    dv_edge;
    logic [DATA_W-1:0]       sample;
    logic [DATA_W-1:0]       avg_q;
    logic [DATA_W-1:0]       avg_now;
    logic [SUM_W-1:0]        sum;
    logic [PTR_W-1:0]        wr_ptr;
    logic                    ptr_last;
    logic [DATA_W-1:0]       sbuf [WIN];
    logic [PROD_W-1:0]       product;
    logic [MV_W-1:0]         mv;
    logic                    conv_load;
    logic                    conv_done;
    logic [4*BCD_DIGITS-1:0] conv_bcd;

    assign dv_edge   = Data_Valid && !dv_q;
    assign ptr_last  = (wr_ptr == PTR_W'(WIN - 1));
    assign avg_now   = DATA_W'(sum >> AVG_LOG2);
    assign product   = PROD_W'(avg_now) * PROD_W'(VREF_MV);
    assign mv        = product[PROD_W-1:10];
    assign conv_load = (state == S_SCALE);
    assign Busy      = (state != S_IDLE);

    always_comb begin
        next_state = state;
        case (state)
            S_CLR:   if (ptr_last) next_state = S_IDLE;
            S_IDLE:  if (dv_edge) next_state = S_ACCUM;
            S_ACCUM: next_state = S_SCALE;
            S_SCALE: next_state = S_CONV;
            S_CONV:  if (conv_done) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_CLR;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state        <= S_CLR;
            dv_q         <= 1'b0;
            sample       <= '0;
            sum          <= '0;
            wr_ptr       <= '0;
            avg_q        <= '0;
            Avg_Data     <= '0;
            BCD_Out      <= '0;
            Result_Valid <= 1'b0;
            Overrun      <= 1'b0;
        end else begin
            state        <= next_state;
            Result_Valid <= 1'b0;
            // Edge history is frozen during the clear so a level held across reset still counts once.
            if (state != S_CLR) begin
                dv_q <= Data_Valid;
            end
            if (dv_edge && state != S_IDLE && state != S_CLR) begin
                Overrun <= 1'b1;
            end
            case (state)
                S_CLR: wr_ptr <= ptr_last ? '0 : wr_ptr + PTR_W'(1);
                S_IDLE: begin
                    if (dv_edge) begin
                        sample <= Data_In;
                    end
                end
                S_ACCUM: begin
                    sum    <= sum + SUM_W'(sample) - SUM_W'(sbuf[wr_ptr]);
                    wr_ptr <= ptr_last ? '0 : wr_ptr + PTR_W'(1);
                end
                S_SCALE: avg_q <= avg_now;
                S_DONE: begin
                    Avg_Data     <= avg_q;
                    BCD_Out      <= conv_bcd;
                    Result_Valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Sample window storage; wiped entry by entry while in S_CLR.
    always_ff @(posedge CLK) begin
        if (state == S_CLR) begin
            sbuf[wr_ptr] <= '0;
        end else if (state == S_ACCUM) begin
            sbuf[wr_ptr] <= sample;
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clk   (CLK),
        .rst_n (RSTn),
        .load  (conv_load),
        .bin   (mv),
        .bcd   (conv_bcd),
        .done  (conv_done)
    );

endmodule

// File: tb/tb_ad_avg_bcd.sv
// Directed plus randomized bench for ad_avg_bcd against an arithmetic moving-average model.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_ad_avg_bcd;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic [9:0]  Data_In = '0;
    logic        Data_Valid = 1'b0;
    logic [9:0]  Avg_Data;
    logic [15:0] BCD_Out;
    logic        Result_Valid;
    logic        Busy;
    logic        Overrun;

    int n_assert = 0;
    int n_fail   = 0;

    int win [8];
    int wp = 0;

    always #5 CLK = ~CLK;

    ad_avg_bcd dut (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .Data_In      (Data_In),
        .Data_Valid   (Data_Valid),
        .Avg_Data     (Avg_Data),
        .BCD_Out      (BCD_Out),
        .Result_Valid (Result_Valid),
        .Busy         (Busy),
        .Overrun      (Overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 8; i++) win[i] = 0;
        wp = 0;
    endfunction

    function automatic void model_push(input int v);
        win[wp] = v;
        wp = (wp + 1) % 8;
    endfunction

    function automatic int model_avg();
        int s;
        s = 0;
        for (int i = 0; i < 8; i++) s += win[i];
        return s / 8;
    endfunction

    function automatic int model_bcd();
        int mv;
        mv = (model_avg() * 5000) / 1024;
        return ((mv / 1000) << 12) | (((mv / 100) % 10) << 8) | (((mv / 10) % 10) << 4) | (mv % 10);
    endfunction

    // Reset for two edges, then watch the 8-cycle buffer clear.
    task automatic do_reset(input string tag);
        @(negedge CLK); RSTn = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check({tag, " avg0"}, 32'(Avg_Data), 0);
        check({tag, " bcd0"}, 32'(BCD_Out), 0);
        check({tag, " rv0"}, 32'(Result_Valid), 0);
        check({tag, " ovr0"}, 32'(Overrun), 0);
        RSTn = 1'b1;
        check({tag, " busy_clr"}, 32'(Busy), 1);
        for (int i = 1; i <= 8; i++) begin
            @(negedge CLK);
            if (i == 7) check({tag, " busy_clr_end"}, 32'(Busy), 1);
            if (i == 8) check({tag, " busy_idle"}, 32'(Busy), 0);
        end
        model_clear();
    endtask

    // One sample, then wait for its result and compare against the model.
    task automatic send(input int val, input string tag);
        int hit;
        model_push(val);
        @(negedge CLK); Data_In = 10'(val); Data_Valid = 1'b1;
        @(negedge CLK); Data_Valid = 1'b0;
        hit = -1;
        for (int k = 1; k <= 40 && hit < 0; k++) begin
            @(negedge CLK);
            if (Result_Valid) hit = k;
        end
        check({tag, " latency"}, hit, 17);
        check({tag, " avg"}, 32'(Avg_Data), model_avg());
        check({tag, " bcd"}, 32'(BCD_Out), model_bcd());
        @(negedge CLK);
        check({tag, " rv_pulse"}, 32'(Result_Valid), 0);
    endtask

    initial begin
        int pulses;
        int v;

        do_reset("init");

        send(1023, "single1023");
        check("single1023 avg_const", 32'(Avg_Data), 127);
        check("single1023 bcd_const", 32'(BCD_Out), 32'h0620);

        do_reset("rst2");
        for (int i = 0; i < 8; i++) send(512, "ramp512");
        check("ramp512 avg_const", 32'(Avg_Data), 512);
        check("ramp512 bcd_const", 32'(BCD_Out), 32'h2500);

        do_reset("rst3");
        for (int i = 0; i < 8; i++) send(1023, "hi1023");
        check("hi1023 bcd_const", 32'(BCD_Out), 32'h4995);
        for (int i = 0; i < 8; i++) send(0, "down0");
        check("down0 bcd_const", 32'(BCD_Out), 32'h0000);

        // Second edge 5 cycles after the first must be dropped.
        model_push(300);
        @(negedge CLK); Data_In = 10'd300; Data_Valid = 1'b1;
        @(negedge CLK); Data_Valid = 1'b0;
        repeat (3) @(negedge CLK);
        @(negedge CLK); Data_In = 10'd999; Data_Valid = 1'b1;
        @(negedge CLK); Data_Valid = 1'b0;
        pulses = 0;
        for (int k = 6; k <= 45; k++) begin
            @(negedge CLK);
            if (Result_Valid) pulses++;
        end
        check("overrun pulses", pulses, 1);
        check("overrun flag", 32'(Overrun), 1);
        check("overrun avg", 32'(Avg_Data), model_avg());
        send(700, "after_ovr");
        check("overrun sticky", 32'(Overrun), 1);

        // Level held high gives a single conversion.
        model_push(850);
        @(negedge CLK); Data_In = 10'd850; Data_Valid = 1'b1;
        pulses = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge CLK);
            if (Result_Valid) pulses++;
        end
        Data_Valid = 1'b0;
        check("level pulses", pulses, 1);
        check("level avg", 32'(Avg_Data), model_avg());
        check("level bcd", 32'(BCD_Out), model_bcd());

        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            v = int'($urandom_range(0, 1023));
            send(v, "random");
        end

        // Reset in the middle of a conversion aborts it.
        @(negedge CLK); Data_In = 10'd777; Data_Valid = 1'b1;
        @(negedge CLK); Data_Valid = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge CLK);
            if (Result_Valid) pulses++;
        end
        RSTn = 1'b0;
        @(negedge CLK);
        check("abort avg0", 32'(Avg_Data), 0);
        check("abort bcd0", 32'(BCD_Out), 0);
        check("abort ovr0", 32'(Overrun), 0);
        RSTn = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) @(negedge CLK);
            if (Result_Valid) pulses++;
            check("abort busy", 32'(Busy), (i < 8) ? 1 : 0);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (Result_Valid) pulses++;
        end
        check("abort no_rv", pulses, 0);
        model_clear();
        send(512, "post_abort");
        check("post_abort avg_const", 32'(Avg_Data), 64);
        check("post_abort bcd_const", 32'(BCD_Out), 32'h0312);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
